// File: rtl/shift_add_mult_seq.sv
// rtl/shift_add_mult_seq.sv - sequential shift-and-add multiplier, unsigned or two's-complement
// One add/shift step per clock. The product is published on completion and held until the next one.
module shift_add_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_signed,
  input  logic                 i_abort,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       a_ext, add_ext, sum;
  logic                 last_step;

  // The multiplier's sign bit carries negative weight, so the final signed step subtracts.
  always_comb begin
    addend    = q_q[0] ? m_q : '0;
    a_ext     = mode_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    add_ext   = mode_q ? {addend[WIDTH-1], addend} : {1'b0, addend};
    last_step = (cnt_q == CNT_W'(WIDTH-1));
    sum       = (mode_q && last_step) ? (a_ext - add_ext) : (a_ext + add_ext);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          a_d     = '0;
          q_d     = i_mplier;
          m_d     = i_mcand;
          mode_d  = i_signed;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          a_d   = sum[WIDTH:1];
          q_d   = {sum[0], q_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (last_step) begin
            prod_d  = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      prod_q  <= prod_d;
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_busy    = (state_q == S_RUN);
  assign o_done    = (state_q == S_DONE);
  assign o_product = prod_q;

endmodule
